lcd_bus_arbiter: RTL and testbench
==================================

// Module: lcd_bus_arbiter
// PURPOSE
//  Owns the 8080-style write bus to the LCD panel: lcd_d, lcd_wr, lcd_rd, lcd_rs, lcd_cs, lcd_rst.
//  Runs the panel power-on reset sequence, then shares the bus between two byte-stream requesters.
//  Requester 0 is the terminal renderer; requester 1 is the status/overlay writer.
//  Arbitration is round-robin at transaction granularity, with burst locking and a lock timeout.
//  The block generates all write-strobe timing.
// PARAMETERS
//  WR_LOW   2      cycles lcd_wr held low per byte (>=1)
//  WR_HIGH  2      cycles lcd_wr held high after the rising edge, data held (>=1)
//  RST_LOW  1000   cycles lcd_rst held low after reset (>=1)
//  RST_WAIT 5000   cycles after lcd_rst rises before init_done (>=1)
//  LOCK_TO  255    idle cycles a locked owner may stall before its lock is dropped (>=1)
//  CNT_W    16     width of the shared timing counter; every cycle parameter must be < 2**CNT_W
// PORTS
//  clk         in   1  system clock
//  rst         in   1  synchronous reset, active-high
//  req0_valid  in   1  requester 0 has a byte
//  req0_rs     in   1  requester 0 register-select (0=cmd, 1=data)
//  req0_data   in   8  requester 0 byte
//  req0_last   in   1  byte ends requester 0 transaction
//  req0_ready  out  1  requester 0 byte accepted this cycle (when valid)
//  req1_*      -    -  same five signals for requester 1
//  lcd_d       out  8  panel data bus
//  lcd_wr      out  1  write strobe, active-low
//  lcd_rd      out  1  read strobe, constant 1
//  lcd_rs      out  1  panel register-select
//  lcd_cs      out  1  panel chip-select, active-low
//  lcd_rst     out  1  panel reset, active-low
//  init_done   out  1  panel reset sequence complete
//  grant       out  1  index of the last accepted requester
//  busy        out  1  1 in any state other than IDLE
// BEHAVIOUR
//  Reset values (rst=1, sync): state=RST_ASSERT, lcd_rst=0, lcd_cs=1, lcd_wr=1, lcd_rd=1, lcd_rs=0, lcd_d=0.
//   Also: init_done=0, ready=0, lock=0, grant=1, so requester 0 wins the first tie.
//  States: RST_ASSERT -> RST_RELEASE -> IDLE -> SETUP -> WR_LO -> WR_HI -> IDLE.
//  RST_ASSERT: lcd_rst=0 for RST_LOW cycles after rst deasserts, then lcd_rst=1 -> RST_RELEASE.
//  RST_RELEASE: RST_WAIT cycles, then init_done=1 (stays 1 until the next rst) -> IDLE.
//  IDLE, arbitration (combinational select):
//   - lock set: only the lock owner is eligible.
//   - lock clear: a single valid requester wins; if both are valid, the one != grant wins.
//   - reqN_ready = (state==IDLE) && sel==N; accept = valid && ready. At most one accept per cycle.
//  On accept, registered at that edge: lcd_d, lcd_rs from the requester; lcd_cs=0; grant=N.
//   - lock=!last; lock owner=N; state -> SETUP.
//  SETUP: 1 cycle, data/rs/cs stable with lcd_wr=1.
//  WR_LO: lcd_wr=0 for WR_LOW cycles.
//  WR_HI: lcd_wr=1 for WR_HIGH cycles, lcd_d held; then -> IDLE.
//   - On entering IDLE with lock=0: lcd_cs=1. With lock=1, lcd_cs stays 0 across the burst.
//  Byte period: 2+WR_LOW+WR_HIGH cycles (6 at defaults) when valid is held back-to-back.
//  Lock timeout: in IDLE with lock=1, count cycles without owner valid.
//   - On reaching LOCK_TO: lock=0, lcd_cs=1, and the counter clears.
//   - The counter clears on every owner accept.
//  Requester data/rs/last must stay stable while valid && !ready. Inputs are ignored before init_done.
//  rst in any state, including mid-strobe, wins. Next edge returns all outputs to reset values.
//   - The in-flight byte is dropped and the reset sequence restarts from RST_ASSERT.
// TESTING
//  1 RST_LOW=4, RST_WAIT=6, rst 1->0: lcd_rst=0 for 4 cycles, then 1.
//    init_done rises 6 cycles later; both ready=0 throughout.
//  2 req0 0x2C, rs=0, last=1 after init: at the accept edge, cs=0 and d=0x2C.
//    wr=0 on cycles +2..+3 after accept; cs=1 at +6; next accept no earlier than +6.
//  3 Both valid continuously, last=1: accept order 0,1,0,1, each cs-framed separately.
//  4 req0 bytes 0x11/0x22/0x33 (last=0,0,1) with req1 valid: req1 is accepted only after 0x33.
//    cs stays 0 across all three req0 bytes.
//  5 LOCK_TO=8: req0 byte last=0, then req0_valid=0 with req1 valid.
//    8 IDLE cycles later: cs=1, and req1 is accepted on the next cycle.
//  6 rst pulsed during WR_LO: next edge wr=1, cs=1, lcd_rst=0, init_done=0, busy=1.
//    The sequence from scenario 1 repeats.

Source files
------------

// File: rtl/lcd_bus_arbiter.sv
// Owns the 8080-style LCD write bus: runs the panel power-on reset sequence, then
// shares the bus between two byte streams with round-robin, burst locking and a lock timeout.
module lcd_bus_arbiter #(
  parameter int WR_LOW   = 2,
  parameter int WR_HIGH  = 2,
  parameter int RST_LOW  = 1000,
  parameter int RST_WAIT = 5000,
  parameter int LOCK_TO  = 255,
  parameter int CNT_W    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req0_rs,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic       req1_rs,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [7:0] lcd_d,
  output logic       lcd_wr,
  output logic       lcd_rd,
  output logic       lcd_rs,
  output logic       lcd_cs,
  output logic       lcd_rst,
  output logic       init_done,
  output logic       grant,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_RST_ASSERT,
    S_RST_RELEASE,
    S_IDLE,
    S_SETUP,
    S_WR_LO,
    S_WR_HI
  } state_t;

  localparam logic [CNT_W-1:0] RST_LOW_END  = CNT_W'(RST_LOW - 1);
  localparam logic [CNT_W-1:0] RST_WAIT_END = CNT_W'(RST_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOW_END   = CNT_W'(WR_LOW - 1);
  localparam logic [CNT_W-1:0] WR_HIGH_END  = CNT_W'(WR_HIGH - 1);
  localparam logic [CNT_W-1:0] LOCK_TO_END  = CNT_W'(LOCK_TO - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [7:0]       d_q, d_n;
  logic             rs_q, rs_n, cs_q, cs_n, wr_q, wr_n, lrst_q, lrst_n;
  logic             init_q, init_n, grant_q, grant_n, lock_q, lock_n, owner_q, owner_n;

  logic       sel, eligible, idle, sel_valid, accept, sel_rs, sel_last;
  logic [7:0] sel_data;

  // A held lock pins the choice to its owner; otherwise a tie goes to whoever was not granted last.
  always_comb begin
    sel      = 1'b0;
    eligible = 1'b0;
    if (lock_q) begin
      sel      = owner_q;
      eligible = 1'b1;
    end else if (req0_valid && req1_valid) begin
      sel      = ~grant_q;
      eligible = 1'b1;
    end else if (req0_valid) begin
      sel      = 1'b0;
      eligible = 1'b1;
    end else if (req1_valid) begin
      sel      = 1'b1;
      eligible = 1'b1;
    end
  end

  assign idle       = (state == S_IDLE);
  assign req0_ready = idle && eligible && !sel;
  assign req1_ready = idle && eligible && sel;
  assign sel_valid  = sel ? req1_valid : req0_valid;
  assign sel_data   = sel ? req1_data : req0_data;
  assign sel_rs     = sel ? req1_rs : req0_rs;
  assign sel_last   = sel ? req1_last : req0_last;
  assign accept     = idle && eligible && sel_valid;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    d_n     = d_q;
    rs_n    = rs_q;
    cs_n    = cs_q;
    wr_n    = wr_q;
    lrst_n  = lrst_q;
    init_n  = init_q;
    grant_n = grant_q;
    lock_n  = lock_q;
    owner_n = owner_q;
    case (state)
      S_RST_ASSERT: begin
        if (cnt == RST_LOW_END) begin
          lrst_n  = 1'b1;
          cnt_n   = '0;
          state_n = S_RST_RELEASE;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      S_RST_RELEASE: begin
        if (cnt == RST_WAIT_END) begin
          init_n  = 1'b1;
          cnt_n   = '0;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      S_IDLE: begin
        if (accept) begin
          d_n     = sel_data;
          rs_n    = sel_rs;
          cs_n    = 1'b0;
          grant_n = sel;
          lock_n  = !sel_last;
          owner_n = sel;
          cnt_n   = '0;
          state_n = S_SETUP;
        end else if (lock_q) begin
          // Owner stalled mid-burst: release the bus once the stall reaches the timeout.
          if (cnt == LOCK_TO_END) begin
            lock_n = 1'b0;
            cs_n   = 1'b1;
            cnt_n  = '0;
          end else begin
            cnt_n = cnt + CNT_ONE;
          end
        end
      end
      S_SETUP: begin
        wr_n    = 1'b0;
        cnt_n   = '0;
        state_n = S_WR_LO;
      end
      S_WR_LO: begin
        if (cnt == WR_LOW_END) begin
          wr_n    = 1'b1;
          cnt_n   = '0;
          state_n = S_WR_HI;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      S_WR_HI: begin
        if (cnt == WR_HIGH_END) begin
          cnt_n   = '0;
          state_n = S_IDLE;
          if (!lock_q) cs_n = 1'b1;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: begin
        state_n = S_RST_ASSERT;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_RST_ASSERT;
      cnt     <= '0;
      d_q     <= 8'h00;
      rs_q    <= 1'b0;
      cs_q    <= 1'b1;
      wr_q    <= 1'b1;
      lrst_q  <= 1'b0;
      init_q  <= 1'b0;
      grant_q <= 1'b1;
      lock_q  <= 1'b0;
      owner_q <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      d_q     <= d_n;
      rs_q    <= rs_n;
      cs_q    <= cs_n;
      wr_q    <= wr_n;
      lrst_q  <= lrst_n;
      init_q  <= init_n;
      grant_q <= grant_n;
      lock_q  <= lock_n;
      owner_q <= owner_n;
    end
  end

  assign lcd_d     = d_q;
  assign lcd_wr    = wr_q;
  assign lcd_rd    = 1'b1;
  assign lcd_rs    = rs_q;
  assign lcd_cs    = cs_q;
  assign lcd_rst   = lrst_q;
  assign init_done = init_q;
  assign grant     = grant_q;
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Scoreboard bench for lcd_bus_arbiter: a transaction-level round-robin model predicts
// the byte stream on the panel bus; directed passes cover reset, strobe timing and lock timeout.
module tb_lcd_bus_arbiter;

  localparam int WR_LOW   = 2;
  localparam int WR_HIGH  = 2;
  localparam int RST_LOW  = 4;
  localparam int RST_WAIT = 6;
  localparam int LOCK_TO  = 8;
  localparam int BYTE_PER = 2 + WR_LOW + WR_HIGH;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req0_rs = 1'b0, req0_last = 1'b0;
  logic [7:0] req0_data = 8'h00;
  logic       req1_valid = 1'b0, req1_rs = 1'b0, req1_last = 1'b0;
  logic [7:0] req1_data = 8'h00;
  logic       req0_ready, req1_ready;
  logic [7:0] lcd_d;
  logic       lcd_wr, lcd_rd, lcd_rs, lcd_cs, lcd_rst, init_done, grant, busy;

  lcd_bus_arbiter #(
    .WR_LOW(WR_LOW), .WR_HIGH(WR_HIGH), .RST_LOW(RST_LOW),
    .RST_WAIT(RST_WAIT), .LOCK_TO(LOCK_TO), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_data(req0_data),
    .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_data(req1_data),
    .req1_last(req1_last), .req1_ready(req1_ready),
    .lcd_d(lcd_d), .lcd_wr(lcd_wr), .lcd_rd(lcd_rd), .lcd_rs(lcd_rs),
    .lcd_cs(lcd_cs), .lcd_rst(lcd_rst), .init_done(init_done),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       rs;
    logic       last;
  } byte_t;

  typedef struct {
    int         req;
    logic       rs;
    logic [7:0] data;
    bit         first;
  } beat_t;

  int    total = 0;
  int    bad = 0;
  beat_t exp_q[$];
  byte_t src[2][$];
  int    lens[2][$];

  int cyc = 0;
  int last_acc = -1;
  int last_acc0 = -1;
  int last_acc1 = -1;
  int cs_rise = -1;

  task automatic checkOutput(input string name, input int unsigned actual, input int unsigned required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, required);
    end
  endtask

  // Presents one byte on requester n and waits for it to be accepted; returns on the
  // negedge after the accept edge (or after the cycle budget runs out).
  task automatic applyStimulus(input int n, input byte_t b, output bit ok);
    ok = 1'b0;
    if (n == 0) begin
      req0_valid = 1'b1; req0_data = b.data; req0_rs = b.rs; req0_last = b.last;
    end else begin
      req1_valid = 1'b1; req1_data = b.data; req1_rs = b.rs; req1_last = b.last;
    end
    for (int c = 0; c < 1000; c++) begin
      #4;
      if ((n == 0) ? req0_ready : req1_ready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
  endtask

  // Called at a negedge after an rst edge; walks the panel reset sequence.
  task automatic resetSequence(input bit hold_req);
    checkOutput("rst_lcd_rst", lcd_rst, 0);
    checkOutput("rst_lcd_cs", lcd_cs, 1);
    checkOutput("rst_lcd_wr", lcd_wr, 1);
    checkOutput("rst_lcd_rd", lcd_rd, 1);
    checkOutput("rst_lcd_rs", lcd_rs, 0);
    checkOutput("rst_lcd_d", lcd_d, 0);
    checkOutput("rst_init_done", init_done, 0);
    checkOutput("rst_grant", grant, 1);
    checkOutput("rst_busy", busy, 1);
    rst = 1'b0;
    if (hold_req) begin
      req1_valid = 1'b1; req1_data = 8'hEE; req1_rs = 1'b1; req1_last = 1'b1;
    end
    for (int i = 1; i <= RST_LOW + RST_WAIT; i++) begin
      @(negedge clk);
      checkOutput($sformatf("seq_lcd_rst_%0d", i), lcd_rst, (i >= RST_LOW) ? 1 : 0);
      checkOutput($sformatf("seq_init_done_%0d", i), init_done, (i >= RST_LOW + RST_WAIT) ? 1 : 0);
      if (i < RST_LOW + RST_WAIT) begin
        checkOutput($sformatf("seq_ready_%0d", i), {req1_ready, req0_ready}, 0);
        checkOutput($sformatf("seq_busy_%0d", i), busy, 1);
      end
    end
    req1_valid = 1'b0;
  endtask

  // Byte monitor: every rising lcd_wr completes a byte on the panel bus.
  initial begin
    logic wr_prev;
    bit   cs_high_since;
    beat_t e;
    wr_prev = 1'b1;
    cs_high_since = 1'b1;
    forever begin
      @(negedge clk);
      if (lcd_cs === 1'b1) cs_high_since = 1'b1;
      if (wr_prev === 1'b0 && lcd_wr === 1'b1 && lcd_rst === 1'b1) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_byte", lcd_d, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          checkOutput("byte_grant", grant, e.req);
          checkOutput("byte_rs", lcd_rs, e.rs);
          checkOutput("byte_data", lcd_d, e.data);
          checkOutput("byte_cs_low", lcd_cs, 0);
          checkOutput("byte_cs_framing", cs_high_since, e.first);
        end
        cs_high_since = 1'b0;
      end
      wr_prev = lcd_wr;
    end
  end

  // Accept tracker, sampled just before each rising edge.
  initial begin
    logic cs_prev;
    bit a0, a1;
    cs_prev = 1'b1;
    forever begin
      @(negedge clk);
      #4;
      cyc++;
      if (lcd_cs === 1'b1 && cs_prev === 1'b0) cs_rise = cyc;
      cs_prev = lcd_cs;
      a0 = (req0_valid && req0_ready);
      a1 = (req1_valid && req1_ready);
      if (a0 || a1) begin
        if (a0 && a1) checkOutput("dual_accept", 1, 0);
        if (last_acc >= 0) checkOutput("byte_period", ((cyc - last_acc) >= BYTE_PER) ? 1 : 0, 1);
        last_acc = cyc;
        if (a0) last_acc0 = cyc;
        else last_acc1 = cyc;
      end
    end
  end

  initial begin
    bit ok;
    int nt[2];
    int ti[2];
    int p[2];
    int turn;
    int who;
    int wait_c;

    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    resetSequence(1'b0);

    // Random phase: both requesters keep valid high; transactions should alternate 0,1,0,1...
    for (int n = 0; n < 2; n++) begin
      nt[n] = $urandom_range(2, 5);
      for (int t = 0; t < nt[n]; t++) begin
        int len;
        len = $urandom_range(1, 4);
        lens[n].push_back(len);
        for (int k = 0; k < len; k++) begin
          byte_t b;
          b.data = 8'($urandom);
          b.rs   = 1'($urandom);
          b.last = (k == len - 1);
          src[n].push_back(b);
        end
      end
    end
    ti = '{0, 0};
    p = '{0, 0};
    turn = 0;
    while (ti[0] < nt[0] || ti[1] < nt[1]) begin
      if (ti[0] < nt[0] && ti[1] < nt[1]) who = turn;
      else who = (ti[0] < nt[0]) ? 0 : 1;
      turn = 1 - who;
      for (int k = 0; k < lens[who][ti[who]]; k++) begin
        exp_q.push_back('{req: who, rs: src[who][p[who]].rs, data: src[who][p[who]].data, first: (k == 0)});
        p[who]++;
      end
      ti[who]++;
    end

    fork
      begin
        bit ok0;
        for (int i = 0; i < src[0].size(); i++) begin
          applyStimulus(0, src[0][i], ok0);
          if (!ok0) begin
            checkOutput("accept_timeout_req0", 0, 1);
            break;
          end
        end
        req0_valid = 1'b0;
      end
      begin
        bit ok1;
        for (int i = 0; i < src[1].size(); i++) begin
          applyStimulus(1, src[1][i], ok1);
          if (!ok1) begin
            checkOutput("accept_timeout_req1", 0, 1);
            break;
          end
        end
        req1_valid = 1'b0;
      end
    join
    wait_c = 0;
    while (exp_q.size() != 0 && wait_c < 50) begin
      @(negedge clk);
      wait_c++;
    end
    checkOutput("random_drain", exp_q.size(), 0);
    repeat (3) @(negedge clk);

    // Single command byte: strobe timing relative to the accept edge.
    exp_q.push_back('{req: 0, rs: 1'b0, data: 8'h2C, first: 1'b1});
    applyStimulus(0, '{data: 8'h2C, rs: 1'b0, last: 1'b1}, ok);
    req0_valid = 1'b0;
    checkOutput("s2_accept", ok, 1);
    checkOutput("s2_cs_p1", lcd_cs, 0);
    checkOutput("s2_d_p1", lcd_d, 8'h2C);
    checkOutput("s2_wr_p1", lcd_wr, 1);
    @(negedge clk);
    checkOutput("s2_wr_p2", lcd_wr, 0);
    @(negedge clk);
    checkOutput("s2_wr_p3", lcd_wr, 0);
    @(negedge clk);
    checkOutput("s2_wr_p4", lcd_wr, 1);
    @(negedge clk);
    checkOutput("s2_cs_p5", lcd_cs, 0);
    @(negedge clk);
    checkOutput("s2_cs_p6", lcd_cs, 1);
    checkOutput("s2_busy_p6", busy, 0);
    repeat (2) @(negedge clk);

    // Lock timeout: req0 opens a burst and stalls while req1 waits.
    exp_q.push_back('{req: 0, rs: 1'b1, data: 8'h5A, first: 1'b1});
    exp_q.push_back('{req: 1, rs: 1'b0, data: 8'hA5, first: 1'b1});
    applyStimulus(0, '{data: 8'h5A, rs: 1'b1, last: 1'b0}, ok);
    req0_valid = 1'b0;
    checkOutput("s5_accept0", ok, 1);
    applyStimulus(1, '{data: 8'hA5, rs: 1'b0, last: 1'b1}, ok);
    req1_valid = 1'b0;
    checkOutput("s5_accept1", ok, 1);
    checkOutput("s5_timeout_gap", last_acc1 - last_acc0, 5 + LOCK_TO + 1);
    checkOutput("s5_cs_release", cs_rise, last_acc1);
    repeat (8) @(negedge clk);
    checkOutput("s5_drain", exp_q.size(), 0);

    // Reset in the middle of a write strobe.
    applyStimulus(0, '{data: 8'h77, rs: 1'b1, last: 1'b1}, ok);
    req0_valid = 1'b0;
    checkOutput("s6_accept", ok, 1);
    @(negedge clk);
    checkOutput("s6_wr_low", lcd_wr, 0);
    rst = 1'b1;
    @(negedge clk);
    resetSequence(1'b1);
    repeat (10) @(negedge clk);
    checkOutput("final_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
